// File: rtl/wb_pkg.sv
// wb_pkg: write-back source encodings and register-file geometry shared by the W stage
package wb_pkg;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        WB_SRC_ALU  = 4'd0,
        WB_SRC_LW   = 4'd1,
        WB_SRC_LBU  = 4'd2,
        WB_SRC_LB   = 4'd3,
        WB_SRC_LHU  = 4'd4,
        WB_SRC_LH   = 4'd5,
        WB_SRC_LINK = 4'd6
    } wb_src_e;
endpackage

// File: rtl/wb_grf_if.sv
// wb_grf_if: W-stage inputs, D-stage read ports and status outputs of the write-back/GRF block
interface wb_grf_if import wb_pkg::*; #(parameter int CNT_W = 32);
    logic [REG_AW-1:0] a3_w;
    logic [31:0]       pc8_w;
    logic [31:0]       ao_w;
    logic [31:0]       dm_w;
    logic [31:0]       instr_w;
    logic [3:0]        memtoreg_w;
    logic              regwrite_w;
    logic [REG_AW-1:0] ra1_d;
    logic [REG_AW-1:0] ra2_d;
    logic [31:0]       rd1_d;
    logic [31:0]       rd2_d;
    logic [31:0]       wd_w;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output a3_w, pc8_w, ao_w, dm_w, instr_w, memtoreg_w, regwrite_w, ra1_d, ra2_d,
        input  rd1_d, rd2_d, wd_w, retire_cnt
    );

    modport slave (
        input  a3_w, pc8_w, ao_w, dm_w, instr_w, memtoreg_w, regwrite_w, ra1_d, ra2_d,
        output rd1_d, rd2_d, wd_w, retire_cnt
    );
endinterface

// File: rtl/wb_load_ext.sv
// wb_load_ext: extracts the addressed byte/halfword from the aligned load word and extends it
module wb_load_ext import wb_pkg::*; (
    input  logic [31:0] dm_i,
    input  logic [1:0]  ba_i,
    input  logic [3:0]  src_i,
    output logic [31:0] ext_o
);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;

    // little-endian lane select, then extension chosen by the load type
    always_comb begin
        sh    = dm_i >> {ba_i, 3'b000};
        b     = sh[7:0];
        h     = ba_i[1] ? dm_i[31:16] : dm_i[15:0];
        ext_o = src_i == WB_SRC_LW  ? dm_i :
                src_i == WB_SRC_LBU ? {24'b0, b} :
                src_i == WB_SRC_LB  ? {{24{b[7]}}, b} :
                src_i == WB_SRC_LHU ? {16'b0, h} :
                src_i == WB_SRC_LH  ? {{16{h[15]}}, h} : 32'b0;
    end
endmodule

// File: rtl/wb_grf.sv
// wb_grf: MIPS write-back mux, 32x32 register file with write-before-read bypass, retire counter
// Optional trace of committed writes when WB_TRACE_EN is defined.
module wb_grf import wb_pkg::*; #(parameter int CNT_W = 32) (
    input logic     clk,
    input logic     reset,
    wb_grf_if.slave bus
);
    logic [31:0]      regs_q [NREG];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ext, wd, rd1, rd2;
    logic             we;

    wb_load_ext u_ext (
        .dm_i  (bus.dm_w),
        .ba_i  (bus.ao_w[1:0]),
        .src_i (bus.memtoreg_w),
        .ext_o (ext)
    );

    // source select, bypassed reads (none while in reset) and counter next state
    always_comb begin
        we    = bus.regwrite_w && bus.a3_w != '0;
        wd    = bus.memtoreg_w == WB_SRC_LINK ? bus.pc8_w :
                bus.memtoreg_w inside {WB_SRC_LW, WB_SRC_LBU, WB_SRC_LB, WB_SRC_LHU, WB_SRC_LH} ? ext :
                bus.ao_w;
        rd1   = reset && we && bus.ra1_d == bus.a3_w ? wd :
                bus.ra1_d == '0 ? 32'b0 : regs_q[bus.ra1_d];
        rd2   = reset && we && bus.ra2_d == bus.a3_w ? wd :
                bus.ra2_d == '0 ? 32'b0 : regs_q[bus.ra2_d];
        cnt_d = cnt_q + CNT_W'(bus.instr_w != '0);
    end

    // register commit and retire count; reset clears everything and blocks the write
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (we) regs_q[bus.a3_w] <= wd;
        end
    end

`ifdef WB_TRACE_EN
    // log each committed write with the instruction's own PC
    always_ff @(posedge clk) begin
        if (reset && we) $display("@%08h: $%d <= %08h", bus.pc8_w - 32'd8, bus.a3_w, wd);
    end
`else
`endif

    assign bus.wd_w       = wd;
    assign bus.rd1_d      = rd1;
    assign bus.rd2_d      = rd2;
    assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_wb_grf.sv
// tb_wb_grf: directed self-checking bench for wb_grf (main 32-bit counter build plus a 4-bit wrap build)
module tb_wb_grf;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   fails = 0;

    wb_grf_if #(.CNT_W(32)) bus ();
    wb_grf_if #(.CNT_W(4))  bus2 ();

    wb_grf #(.CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
    wb_grf #(.CNT_W(4))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.a3_w = 0; bus.pc8_w = 0; bus.ao_w = 0; bus.dm_w = 0; bus.instr_w = 0;
        bus.memtoreg_w = 0; bus.regwrite_w = 0; bus.ra1_d = 0; bus.ra2_d = 0;
        bus2.a3_w = 0; bus2.pc8_w = 0; bus2.ao_w = 0; bus2.dm_w = 0; bus2.instr_w = 0;
        bus2.memtoreg_w = 0; bus2.regwrite_w = 0; bus2.ra1_d = 0; bus2.ra2_d = 0;
        tick; tick;
        reset = 1'b1;
        chk("reset_cnt_init", bus.retire_cnt, 32'd0);
        chk("reset_r0_init", bus.rd1_d, 32'd0);
        bus.a3_w = 5; bus.ao_w = 32'hAAAA5555; bus.regwrite_w = 1; bus.instr_w = 32'h1;
        tick;
        bus.regwrite_w = 0; bus.instr_w = 0; bus.ra1_d = 5;
        #1;
        chk("pre_reset_r5", bus.rd1_d, 32'hAAAA5555);
        chk("pre_reset_cnt", bus.retire_cnt, 32'd1);
        reset = 1'b0;
        bus.a3_w = 5; bus.ao_w = 32'h11111111; bus.regwrite_w = 1; bus.instr_w = 32'h1;
        #1;
        chk("in_reset_no_bypass", bus.rd1_d, 32'hAAAA5555);
        tick; tick;
        reset = 1'b1; bus.regwrite_w = 0; bus.instr_w = 0;
        #1;
        chk("post_reset_r5", bus.rd1_d, 32'd0);
        chk("post_reset_cnt", bus.retire_cnt, 32'd0);
        tick;
        chk("reset_write_discarded", bus.rd1_d, 32'd0);

        bus.a3_w = 8; bus.ao_w = 32'h12345678; bus.memtoreg_w = 0; bus.regwrite_w = 1; bus.ra1_d = 8;
        #1;
        chk("alu_bypass", bus.rd1_d, 32'h12345678);
        tick;
        bus.regwrite_w = 0;
        #1;
        chk("alu_stored", bus.rd1_d, 32'h12345678);

        bus.dm_w = 32'h80FF7F01;
        bus.memtoreg_w = 3; bus.ao_w = 32'h2; #1; chk("lb_b2", bus.wd_w, 32'hFFFFFFFF);
        bus.memtoreg_w = 2; bus.ao_w = 32'h3; #1; chk("lbu_b3", bus.wd_w, 32'h00000080);
        bus.memtoreg_w = 3; bus.ao_w = 32'h0; #1; chk("lb_b0", bus.wd_w, 32'h00000001);
        bus.memtoreg_w = 5; bus.ao_w = 32'h2; #1; chk("lh_h1", bus.wd_w, 32'hFFFF80FF);
        bus.memtoreg_w = 4; bus.ao_w = 32'h0; #1; chk("lhu_h0", bus.wd_w, 32'h00007F01);
        bus.memtoreg_w = 5; bus.ao_w = 32'h1; #1; chk("lh_h0_a0", bus.wd_w, 32'h00007F01);
        bus.memtoreg_w = 1; #1; chk("lw", bus.wd_w, 32'h80FF7F01);
        bus.memtoreg_w = 9; bus.ao_w = 32'h55; #1; chk("reserved_alu", bus.wd_w, 32'h00000055);
        bus.memtoreg_w = 3; bus.ao_w = 32'h2; bus.a3_w = 10; bus.regwrite_w = 1;
        tick;
        bus.regwrite_w = 0; bus.ra2_d = 10;
        #1;
        chk("lb_stored", bus.rd2_d, 32'hFFFFFFFF);

        bus.memtoreg_w = 6; bus.pc8_w = 32'h00003008; bus.a3_w = 31; bus.regwrite_w = 1;
        tick;
        bus.regwrite_w = 0; bus.ra1_d = 31;
        #1;
        chk("link_r31", bus.rd1_d, 32'h00003008);
        bus.a3_w = 0; bus.regwrite_w = 1; bus.ra1_d = 0; bus.ra2_d = 0;
        #1;
        chk("r0_wd", bus.wd_w, 32'h00003008);
        chk("r0_no_bypass1", bus.rd1_d, 32'd0);
        chk("r0_no_bypass2", bus.rd2_d, 32'd0);
        tick;
        bus.regwrite_w = 0;
        #1;
        chk("r0_stays_zero", bus.rd1_d, 32'd0);

        for (int i = 0; i < 8; i++) begin
            bus.instr_w = (i == 1 || i == 4 || i == 6) ? 32'h0 : 32'h2000_0000 + i;
            tick;
        end
        bus.instr_w = 0;
        #1;
        chk("retire_count5", bus.retire_cnt, 32'd5);

        bus.memtoreg_w = 0; bus.ao_w = 32'hDEADBEEF; bus.pc8_w = 32'h00003010;
        bus.a3_w = 9; bus.regwrite_w = 1; bus.ra1_d = 9; bus.ra2_d = 9;
        #1;
        chk("dual_bypass1", bus.rd1_d, 32'hDEADBEEF);
        chk("dual_bypass2", bus.rd2_d, 32'hDEADBEEF);
        tick;
        bus.regwrite_w = 0; bus.ra2_d = 8;
        #1;
        chk("r9_stored", bus.rd1_d, 32'hDEADBEEF);
        chk("r8_kept", bus.rd2_d, 32'h12345678);
        chk("no_count_on_write", bus.retire_cnt, 32'd5);

        bus2.instr_w = 32'h1;
        for (int i = 0; i < 15; i++) tick;
        chk("cnt4_at15", {28'b0, bus2.retire_cnt}, 32'd15);
        tick;
        bus2.instr_w = 0;
        #1;
        chk("cnt4_wrap", {28'b0, bus2.retire_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Write-back stage plus general register file (GRF) of the 5-stage MIPS pipeline.
- Sits directly downstream of the MEM/WB pipeline register and consumes its W-stage outputs.
- Extracts and extends load data, selects the write-back value and commits it to a 32x32 register file.
- Serves the D-stage read ports with internal write-before-read bypass and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- NREG, 32, number of architectural registers; fixed at 32, since register addresses are 5 bits.

Ports:
- clk  in  1  single pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk.
- a3_w  in  5  destination register number.
- pc8_w  in  32  PC+8 of the W-stage instruction.
- ao_w  in  32  ALU result / memory byte address.
- dm_w  in  32  raw aligned word read from data memory.
- instr_w  in  32  W-stage instruction word; 0 = bubble.
- memtoreg_w  in  4  write-back source select.
- regwrite_w  in  1  register write enable.
- ra1_d  in  5  D-stage rs read address.
- ra2_d  in  5  D-stage rt read address.
- rd1_d  out  32  rs read data, bypassed.
- rd2_d  out  32  rt read data, bypassed.
- wd_w  out  32  final write-back value; also the forwarding source for earlier stages.
- retire_cnt  out  CNT_W  count of non-bubble instructions retired.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-low: when reset==0 at a posedge, all 32 registers and retire_cnt clear to 0.
- No register write and no count occur on a reset edge, even if regwrite_w=1.
- memtoreg_w encoding (shared constants):
  - 0 = ALU: ao_w.
  - 1 = LW: dm_w.
  - 2 = LBU: zero-extended byte.
  - 3 = LB: sign-extended byte.
  - 4 = LHU: zero-extended halfword.
  - 5 = LH: sign-extended halfword.
  - 6 = LINK: pc8_w.
  - 7..15 reserved: treated as ALU.
- Byte select is ao_w[1:0], little-endian: 0 selects dm_w[7:0] … 3 selects dm_w[31:24]. Halfword select is ao_w[1]: 0 selects [15:0], 1 selects [31:16]. ao_w[0] is ignored for halfwords, because alignment is checked upstream.
- wd_w is purely combinational from the W-stage inputs; zero latency.
- Write: at posedge with reset==1, regwrite_w==1 and a3_w!=0, the register at a3_w takes wd_w.
- Register 0 is never written and always reads 0.
- Read: rd1_d/rd2_d are combinational.
  - If regwrite_w==1, a3_w!=0 and a3_w==ra1_d (resp. ra2_d), the output is wd_w (same-cycle bypass).
  - Otherwise the output is the stored register.
  - Both ports may bypass simultaneously.
- During reset==0 the read ports still return the stored values, without bypass.
- retire_cnt increments by 1 at each posedge with reset==1 and instr_w!=0, independent of regwrite_w. It wraps from all-ones to 0.
- Simultaneous write and read of the same register: the bypass value is returned; the stored value updates at the edge.

Optional Feature:
- Macro: WB_TRACE_EN.
- When defined: on every committed write (the same condition as the register write), a simulation-only display prints "@<pc8_w-8 hex>: $<a3_w decimal> <= <wd_w hex>", exactly 8-digit hex, in the same edge.
- Writes to $0 are not printed.
- When undefined: no display code exists; RTL behaviour is identical.

Decomposition:
- Package wb_pkg holds the memtoreg_w encodings (WB_SRC_ALU … WB_SRC_LINK) and the NREG/register-address width constants.
- One sub-module, wb_load_ext, is natural: purely combinational, taking (dm_w, ao_w[1:0], memtoreg_w) and producing the extended load value.
- Register array, bypass, source mux and counter stay in wb_grf.

Test Plan:
- Reset: drive reset=0 for 2 cycles after arbitrary writes -> all registers read 0 and retire_cnt=0; a write presented during reset (regwrite_w=1, a3_w=5) is discarded.
- ALU write plus bypass: a3_w=8, ao_w=0x12345678, memtoreg_w=0, regwrite_w=1, ra1_d=8 -> rd1_d=0x12345678 in the same cycle; after the edge with regwrite_w=0, rd1_d is still 0x12345678.
- Load extraction with dm_w=0x80FF7F01:
  - LB at ao_w[1:0]=2 -> 0xFFFFFFFF; LBU at 3 -> 0x00000080.
  - LH at ao_w[1]=1 -> 0xFFFF80FF; LHU at 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Link and $0: memtoreg_w=6, pc8_w=0x00003008, a3_w=31 -> $31=0x00003008. Same transaction with a3_w=0 -> $0 reads 0, no bypass, no trace line.
- Counter: 5 cycles with instr_w≠0 interleaved with 3 bubbles -> retire_cnt=5. Preload CNT_W=4 build at 15 plus one instruction -> wraps to 0.
- Dual bypass: ra1_d=ra2_d=a3_w=9, wd_w=0xDEADBEEF -> both read 0xDEADBEEF; with WB_TRACE_EN and pc8_w=0x3010, log "@00003008: $ 9 <= deadbeef".
